privstack: RTL and testbench

Privilege-stack register block for the `mstatus`/`hstatus` trap-stack fields. It is the writer side of the privilege-mode tracker: on trap entry it pushes the current mode and interrupt-enable state, and on `mret`/`sret` it pops it. It also performs the field-level WARL legalization for CSR writes to these fields. It sits in the privileged unit, between the trap logic, the CSR write path, and the privilege-mode tracker, which consumes `STATUS_MPP`, `STATUS_SPP`, `MSTATUS_MPV` and `HSTATUS_SPV`.

---
 rtl/privstack_pkg.sv | 36 +++
 rtl/privstack_if.sv | 44 ++++
 rtl/privstack_mpplegal.sv | 24 ++
 rtl/privstack.sv | 175 +++++++++++++++++
 tb/tb_privstack.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/privstack_pkg.sv
// Shared configuration, mode encodings and mstatus/hstatus bit positions
// for the privilege-stack register block.
package privstack_pkg;

    typedef struct packed {
        int unsigned XLEN;
        logic        U_SUPPORTED;
        logic        S_SUPPORTED;
        logic        H_SUPPORTED;
    } cvw_t;

    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] S_MODE = 2'b01;
    localparam logic [1:0] U_MODE = 2'b00;

    localparam int MIE_BIT   = 3;
    localparam int SIE_BIT   = 1;
    localparam int MPIE_BIT  = 7;
    localparam int SPIE_BIT  = 5;
    localparam int SPP_BIT   = 8;
    localparam int MPP_LO    = 11;
    localparam int MPP_HI    = 12;
    localparam int MPRV_BIT  = 17;
    localparam int MPV64_BIT = 39;
    localparam int MPVH_BIT  = 7;
    localparam int SPV_BIT   = 7;

    localparam cvw_t CVW_RV64_FULL = '{XLEN: 32'd64, U_SUPPORTED: 1'b1,
                                       S_SUPPORTED: 1'b1, H_SUPPORTED: 1'b1};

    // MPP comes out of reset in the lowest supported mode
    function automatic logic [1:0] mpp_reset_val(input cvw_t p);
        return p.U_SUPPORTED ? U_MODE : M_MODE;
    endfunction

endpackage

// File: rtl/privstack_if.sv
// Event, CSR-write and status-field bundle between the trap/CSR logic
// (master) and the privilege-stack register block (slave).
interface privstack_if #(
    parameter int XLEN = 64
);
    logic            StallW;
    logic            TrapM;
    logic            DelegateM;
    logic            TrapToVS;
    logic            mretM;
    logic            sretM;
    logic [1:0]      PrivilegeModeW;
    logic            VirtModeW;
    logic            WriteMSTATUSM;
    logic            WriteSSTATUSM;
    logic            WriteMSTATUSHM;
    logic            WriteHSTATUSM;
    logic [XLEN-1:0] CSRWriteValM;
    logic            STATUS_MIE;
    logic            STATUS_SIE;
    logic            STATUS_MPIE;
    logic            STATUS_SPIE;
    logic            STATUS_SPP;
    logic            STATUS_MPRV;
    logic [1:0]      STATUS_MPP;
    logic            MSTATUS_MPV;
    logic            HSTATUS_SPV;

    modport master (
        output StallW, TrapM, DelegateM, TrapToVS, mretM, sretM,
               PrivilegeModeW, VirtModeW, WriteMSTATUSM, WriteSSTATUSM,
               WriteMSTATUSHM, WriteHSTATUSM, CSRWriteValM,
        input  STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP,
               STATUS_MPRV, STATUS_MPP, MSTATUS_MPV, HSTATUS_SPV
    );

    modport slave (
        input  StallW, TrapM, DelegateM, TrapToVS, mretM, sretM,
               PrivilegeModeW, VirtModeW, WriteMSTATUSM, WriteSSTATUSM,
               WriteMSTATUSHM, WriteHSTATUSM, CSRWriteValM,
        output STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP,
               STATUS_MPRV, STATUS_MPP, MSTATUS_MPV, HSTATUS_SPV
    );
endinterface

// File: rtl/privstack_mpplegal.sv
// WARL legalization of a CSR write to MPP: reserved or unsupported modes
// leave the current value in place.
module privstack_mpplegal
    import privstack_pkg::*;
#(
    parameter cvw_t P = CVW_RV64_FULL
) (
    input  logic [1:0] wval,
    input  logic [1:0] cur,
    output logic [1:0] legal
);

    // Map each requested mode to itself only when the hart implements it
    always_comb begin
        legal = cur;
        case (wval)
            2'b11:   legal = M_MODE;
            2'b01:   legal = P.S_SUPPORTED ? S_MODE : cur;
            2'b00:   legal = P.U_SUPPORTED ? U_MODE : cur;
            default: legal = cur;
        endcase
    end

endmodule

// File: rtl/privstack.sv
// Privilege-stack fields of mstatus/hstatus: trap push, mret/sret pop and
// field-level CSR writes, one event per un-stalled cycle.
module privstack
    import privstack_pkg::*;
#(
    parameter cvw_t P = CVW_RV64_FULL
) (
    input logic        clk,
    input logic        reset_n,
    privstack_if.slave bus
);

    localparam logic [1:0] MPP_RST = mpp_reset_val(P);
    localparam logic       IS_RV64 = (P.XLEN == 32'd64);
    localparam logic       IS_RV32 = (P.XLEN == 32'd32);

    logic       mie_r, sie_r, mpie_r, spie_r, spp_r, mprv_r, mpv_r, spv_r;
    logic [1:0] mpp_r;
    logic       mie_n_s, sie_n_s, mpie_n_s, spie_n_s, spp_n_s, mprv_n_s;
    logic       mpv_n_s, spv_n_s;
    logic [1:0] mpp_n_s, mpp_legal_s;
    logic [63:0] wval_s;
    logic       unused_wval_s;
    logic       trap_m_s, trap_s_s, ret_m_s, ret_s_s, csr_s;
    logic       wr_m_s, wr_s_s, wr_mh_s, wr_h_s;

    privstack_mpplegal #(.P(P)) u_mpplegal (
        .wval  (wval_s[MPP_HI:MPP_LO]),
        .cur   (mpp_r),
        .legal (mpp_legal_s)
    );

    // Event decode: trap > mret > sret > CSR write, mstatus over sstatus
    always_comb begin
        wval_s        = 64'(bus.CSRWriteValM);
        unused_wval_s = ^wval_s;
        trap_s_s      = bus.TrapM & bus.DelegateM & P.S_SUPPORTED;
        trap_m_s      = bus.TrapM & ~trap_s_s;
        ret_m_s       = ~bus.TrapM & bus.mretM;
        ret_s_s       = ~bus.TrapM & ~bus.mretM & bus.sretM;
        csr_s         = ~bus.TrapM & ~bus.mretM & ~bus.sretM;
        wr_m_s        = csr_s & bus.WriteMSTATUSM;
        wr_s_s        = csr_s & ~bus.WriteMSTATUSM & bus.WriteSSTATUSM;
        wr_mh_s       = csr_s & bus.WriteMSTATUSHM & IS_RV32;
        wr_h_s        = csr_s & bus.WriteHSTATUSM;
    end

    // Next values of the M-level fields
    always_comb begin
        mie_n_s  = mie_r;
        mpie_n_s = mpie_r;
        mpp_n_s  = mpp_r;
        mprv_n_s = mprv_r;
        mpv_n_s  = mpv_r;
        if (trap_m_s) begin
            mie_n_s  = 1'b0;
            mpie_n_s = mie_r;
            mpp_n_s  = bus.PrivilegeModeW;
            mpv_n_s  = bus.VirtModeW;
        end else if (ret_m_s) begin
            mie_n_s  = mpie_r;
            mpie_n_s = 1'b1;
            mpp_n_s  = P.U_SUPPORTED ? U_MODE : M_MODE;
            mprv_n_s = (mpp_r != M_MODE) ? 1'b0 : mprv_r;
            mpv_n_s  = 1'b0;
        end else if (ret_s_s) begin
            mprv_n_s = 1'b0;
        end else if (wr_m_s) begin
            mie_n_s  = wval_s[MIE_BIT];
            mpie_n_s = wval_s[MPIE_BIT];
            mpp_n_s  = mpp_legal_s;
            mprv_n_s = wval_s[MPRV_BIT];
            mpv_n_s  = IS_RV64 ? wval_s[MPV64_BIT] : mpv_r;
        end else if (wr_mh_s) begin
            mpv_n_s  = wval_s[MPVH_BIT];
        end else begin
            mie_n_s  = mie_r;
        end
        // Unimplemented modes pin their fields
        if (!P.U_SUPPORTED) begin
            mpp_n_s  = M_MODE;
            mprv_n_s = 1'b0;
        end else begin
            mprv_n_s = mprv_n_s;
        end
        if (!P.H_SUPPORTED) begin
            mpv_n_s = 1'b0;
        end else begin
            mpv_n_s = mpv_n_s;
        end
    end

    // Next values of the S-level and hypervisor fields
    always_comb begin
        sie_n_s  = sie_r;
        spie_n_s = spie_r;
        spp_n_s  = spp_r;
        spv_n_s  = spv_r;
        if (trap_s_s) begin
            sie_n_s  = 1'b0;
            spie_n_s = sie_r;
            spp_n_s  = bus.PrivilegeModeW[0];
            spv_n_s  = bus.TrapToVS ? spv_r : bus.VirtModeW;
        end else if (ret_s_s) begin
            sie_n_s  = spie_r;
            spie_n_s = 1'b1;
            spp_n_s  = 1'b0;
            spv_n_s  = 1'b0;
        end else if (wr_m_s | wr_s_s) begin
            sie_n_s  = wval_s[SIE_BIT];
            spie_n_s = wval_s[SPIE_BIT];
            spp_n_s  = wval_s[SPP_BIT];
            spv_n_s  = wr_h_s ? wval_s[SPV_BIT] : spv_r;
        end else if (wr_h_s) begin
            spv_n_s  = wval_s[SPV_BIT];
        end else begin
            sie_n_s  = sie_r;
        end
        if (!P.S_SUPPORTED) begin
            sie_n_s  = 1'b0;
            spie_n_s = 1'b0;
            spp_n_s  = 1'b0;
        end else begin
            spp_n_s  = spp_n_s;
        end
        if (!P.H_SUPPORTED) begin
            spv_n_s = 1'b0;
        end else begin
            spv_n_s = spv_n_s;
        end
    end

    // M-level field flops, held while the writeback stage is stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mie_r  <= 1'b0;
            mpie_r <= 1'b0;
            mpp_r  <= MPP_RST;
            mprv_r <= 1'b0;
            mpv_r  <= 1'b0;
        end else if (!bus.StallW) begin
            mie_r  <= mie_n_s;
            mpie_r <= mpie_n_s;
            mpp_r  <= mpp_n_s;
            mprv_r <= mprv_n_s;
            mpv_r  <= mpv_n_s;
        end
    end

    // S-level and hypervisor field flops, held while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sie_r  <= 1'b0;
            spie_r <= 1'b0;
            spp_r  <= 1'b0;
            spv_r  <= 1'b0;
        end else if (!bus.StallW) begin
            sie_r  <= sie_n_s;
            spie_r <= spie_n_s;
            spp_r  <= spp_n_s;
            spv_r  <= spv_n_s;
        end
    end

    assign bus.STATUS_MIE  = mie_r;
    assign bus.STATUS_SIE  = sie_r;
    assign bus.STATUS_MPIE = mpie_r;
    assign bus.STATUS_SPIE = spie_r;
    assign bus.STATUS_SPP  = spp_r;
    assign bus.STATUS_MPRV = mprv_r;
    assign bus.STATUS_MPP  = mpp_r;
    assign bus.MSTATUS_MPV = mpv_r;
    assign bus.HSTATUS_SPV = spv_r;

endmodule

// File: tb/tb_privstack.sv
// Directed bench for privstack: a full RV64 (U/S/H) instance and an RV32
// instance without S-mode, driven from a vector table plus corner sequences.
module tb_privstack;
    import privstack_pkg::*;

    localparam cvw_t CFG64 = '{XLEN: 32'd64, U_SUPPORTED: 1'b1,
                               S_SUPPORTED: 1'b1, H_SUPPORTED: 1'b1};
    localparam cvw_t CFG32 = '{XLEN: 32'd32, U_SUPPORTED: 1'b1,
                               S_SUPPORTED: 1'b0, H_SUPPORTED: 1'b1};

    // control word: {stall, trap, deleg, tovs, mret, sret, wm, ws, wmh, whs}
    localparam logic [9:0] C_STALL = 10'b1000000000;
    localparam logic [9:0] C_TRAP  = 10'b0100000000;
    localparam logic [9:0] C_DELEG = 10'b0010000000;
    localparam logic [9:0] C_TOVS  = 10'b0001000000;
    localparam logic [9:0] C_MRET  = 10'b0000100000;
    localparam logic [9:0] C_SRET  = 10'b0000010000;
    localparam logic [9:0] C_WM    = 10'b0000001000;
    localparam logic [9:0] C_WS    = 10'b0000000100;
    localparam logic [9:0] C_WMH   = 10'b0000000010;
    localparam logic [9:0] C_WHS   = 10'b0000000001;

    typedef struct {
        string       nm;
        bit          dut;
        logic [9:0]  ctl;
        logic [1:0]  priv;
        logic        virt;
        logic [63:0] wv;
        logic [9:0]  exp;   // {mie,sie,mpie,spie,spp,mprv,mpp[1:0],mpv,spv}
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    privstack_if #(.XLEN(64)) b64 ();
    privstack_if #(.XLEN(32)) b32 ();

    privstack #(.P(CFG64)) dut64 (.clk(clk), .reset_n(reset_n), .bus(b64));
    privstack #(.P(CFG32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32));

    always #5 clk = ~clk;

    task automatic add(input string nm, input bit dut, input logic [9:0] ctl,
                       input logic [1:0] priv, input logic virt,
                       input logic [63:0] wv, input logic [9:0] exp);
        vec_t v;
        v.nm = nm; v.dut = dut; v.ctl = ctl; v.priv = priv;
        v.virt = virt; v.wv = wv; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit dut, input logic [9:0] ctl,
                         input logic [1:0] priv, input logic virt,
                         input logic [63:0] wv);
        if (dut == 1'b0) begin
            {b64.StallW, b64.TrapM, b64.DelegateM, b64.TrapToVS, b64.mretM,
             b64.sretM, b64.WriteMSTATUSM, b64.WriteSSTATUSM,
             b64.WriteMSTATUSHM, b64.WriteHSTATUSM} = ctl;
            b64.PrivilegeModeW = priv;
            b64.VirtModeW      = virt;
            b64.CSRWriteValM   = wv;
        end else begin
            {b32.StallW, b32.TrapM, b32.DelegateM, b32.TrapToVS, b32.mretM,
             b32.sretM, b32.WriteMSTATUSM, b32.WriteSSTATUSM,
             b32.WriteMSTATUSHM, b32.WriteHSTATUSM} = ctl;
            b32.PrivilegeModeW = priv;
            b32.VirtModeW      = virt;
            b32.CSRWriteValM   = wv[31:0];
        end
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, 2'b00, 1'b0, 64'd0);
        drive(1'b1, 10'd0, 2'b00, 1'b0, 64'd0);
    endtask

    function automatic logic [9:0] fields(input bit dut);
        if (dut == 1'b0)
            return {b64.STATUS_MIE, b64.STATUS_SIE, b64.STATUS_MPIE,
                    b64.STATUS_SPIE, b64.STATUS_SPP, b64.STATUS_MPRV,
                    b64.STATUS_MPP, b64.MSTATUS_MPV, b64.HSTATUS_SPV};
        else
            return {b32.STATUS_MIE, b32.STATUS_SIE, b32.STATUS_MPIE,
                    b32.STATUS_SPIE, b32.STATUS_SPP, b32.STATUS_MPRV,
                    b32.STATUS_MPP, b32.MSTATUS_MPV, b32.HSTATUS_SPV};
    endfunction

    task automatic chk(input string nm, input logic [9:0] got,
                       input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    // Present one event for a single clock edge, then compare just after it
    task automatic apply(input vec_t v);
        drive(v.dut, v.ctl, v.priv, v.virt, v.wv);
        @(posedge clk);
        #1;
        idle();
        chk(v.nm, fields(v.dut), v.exp);
    endtask

    initial begin
        vec_t hv;
        idle();

        // RV64 full configuration, state carried from row to row
        add("wr_mstatus",        1'b0, C_WM, 2'b00, 1'b0, 64'h2088A,          10'b111001_01_00);
        add("mret_mpp01",        1'b0, C_MRET, 2'b00, 1'b0, 64'h0,            10'b111000_00_00);
        add("wr_mpp11_mprv",     1'b0, C_WM, 2'b00, 1'b0, 64'h21882,          10'b011001_11_00);
        add("mret_mpp11_keep",   1'b0, C_MRET, 2'b00, 1'b0, 64'h0,            10'b111001_00_00);
        add("trap_m_from_u",     1'b0, C_TRAP, 2'b00, 1'b1, 64'h0,            10'b011001_00_10);
        add("deleg_trap_tovs",   1'b0, C_TRAP | C_DELEG | C_TOVS, 2'b01, 1'b1, 64'h0, 10'b001111_00_10);
        add("deleg_trap_hs",     1'b0, C_TRAP | C_DELEG, 2'b00, 1'b1, 64'h0,  10'b001001_00_11);
        add("sret",              1'b0, C_SRET, 2'b00, 1'b0, 64'h0,            10'b001100_00_10);
        add("wr_mpp10_warl",     1'b0, C_WM, 2'b00, 1'b0, 64'h1008,           10'b100000_00_00);
        add("wr_mpp01_mpv64",    1'b0, C_WM, 2'b00, 1'b0, 64'h80_0000_0808,   10'b100000_01_10);
        add("trap_beats_mret_wr",1'b0, C_TRAP | C_MRET | C_WM, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 10'b001000_01_00);
        add("stall_holds",       1'b0, C_STALL | C_TRAP | C_SRET | C_WM, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 10'b001000_01_00);
        add("wr_sstatus",        1'b0, C_WS, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 10'b011110_01_00);
        add("wr_hstatus_spv",    1'b0, C_WHS, 2'b00, 1'b0, 64'h80,            10'b011110_01_01);
        add("sret_pop",          1'b0, C_SRET, 2'b00, 1'b0, 64'h0,            10'b011100_01_00);
        add("wr_mstatush_rv64",  1'b0, C_WMH, 2'b00, 1'b0, 64'h80,            10'b011100_01_00);
        // RV32 without S-mode
        add("ns_wr_mpp01_warl",  1'b1, C_WM, 2'b00, 1'b0, 64'h80A,            10'b100000_00_00);
        add("ns_wr_mpp11",       1'b1, C_WM, 2'b00, 1'b0, 64'h1800,           10'b000000_11_00);
        add("ns_deleg_is_m_trap",1'b1, C_TRAP | C_DELEG, 2'b00, 1'b1, 64'h0,  10'b000000_00_10);
        add("ns_wr_mstatush",    1'b1, C_WMH, 2'b00, 1'b0, 64'h0,             10'b000000_00_00);
        add("ns_wr_sstatus",     1'b1, C_WS, 2'b00, 1'b0, 64'hFFFF_FFFF,      10'b000000_00_00);
        add("ns_wr_mstatus_ones",1'b1, C_WM, 2'b00, 1'b0, 64'hFFFF_FFFF,      10'b101001_11_00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rv64", fields(1'b0), 10'b000000_00_00);
        chk("reset_rv32", fields(1'b1), 10'b000000_00_00);
        reset_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // mret: outputs keep the pre-return values during the mret cycle
        drive(1'b0, C_MRET, 2'b00, 1'b0, 64'h0);
        #1;
        chk("mret_same_cycle", fields(1'b0), 10'b011100_01_00);
        @(posedge clk);
        #1;
        idle();
        chk("mret_next_cycle", fields(1'b0), 10'b111100_00_00);

        // Asynchronous reset between edges
        hv.nm = "wr_mie_mpp01"; hv.dut = 1'b0; hv.ctl = C_WM; hv.priv = 2'b00;
        hv.virt = 1'b0; hv.wv = 64'h808; hv.exp = 10'b100000_01_00;
        apply(hv);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_rv64", fields(1'b0), 10'b000000_00_00);
        chk("async_reset_rv32", fields(1'b1), 10'b000000_00_00);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, C_WM, 2'b00, 1'b0, 64'h8);
        @(posedge clk);
        #1;
        idle();
        chk("first_edge_after_reset", fields(1'b0), 10'b100000_00_00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
